// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: default geometry, link state encoding and a width helper.
package tdm_pkg;

  localparam int unsigned DEFAULT_BIT_WIDTH = 24;
  localparam int unsigned DEFAULT_SLOTS     = 4;
  localparam int unsigned DEFAULT_SLOT_BITS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_sck_gen.sv
// Serial clock divider: sck level plus single-clk rise/fall strobes, CLK_DIV clk per period.
module tdm_sck_gen
  import tdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned CNT_W = clog2_min1(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;

  // Strobes mark the clk edge on which sck changes level.
  assign rise_c = en && (cnt_q == CNT_W'(HALF - 1));
  assign fall_c = en && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else begin
      cnt_q <= fall_c ? '0 : cnt_q + CNT_W'(1);
      if (rise_c) begin
        sck <= 1'b1;
      end else if (fall_c) begin
        sck <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_transmit.sv
// TDM serial transmitter with a one-frame shadow buffer and valid/ready intake.
// Build option TDM_TX_REPEAT_EN: on underrun resend the previous frame instead of zeros.
module tdm_transmit
  import tdm_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int unsigned SLOTS     = DEFAULT_SLOTS,
  parameter int unsigned SLOT_BITS = DEFAULT_SLOT_BITS,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       enable_in,
  input  logic [SLOTS*BIT_WIDTH-1:0] samples_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output logic                       sck_out,
  output logic                       ws_out,
  output logic                       sd_out,
  output logic                       underrun_out
);

  localparam int unsigned FRAME_W = SLOTS * BIT_WIDTH;
  localparam int unsigned SLOT_W  = clog2_min1(SLOTS);
  localparam int unsigned POS_W   = clog2_min1(SLOT_BITS);

  tdm_state_e         state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d, slot_n;
  logic [POS_W-1:0]   pos_q, pos_d, pos_n;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic               ready_q, ready_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic               ur_q, ur_d;
  logic               sck_rise_c, sck_fall_c;
  logic               last_bit_c, sync_next_c, accept_c;
  logic               unused_rise;

  tdm_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .en     (state_q == RUN),
    .sck    (sck_out),
    .rise_c (sck_rise_c),
    .fall_c (sck_fall_c)
  );

  assign unused_rise = sck_rise_c;

  // Serial bit of frame f at (slot s, position p): MSB first, left-justified, zero padded.
  function automatic logic bit_at(input logic [FRAME_W-1:0] f,
                                  input logic [SLOT_W-1:0]  s,
                                  input logic [POS_W-1:0]   p);
    logic [BIT_WIDTH-1:0] word;
    logic                 b;
    word = '0;
    b    = 1'b0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (s == SLOT_W'(k)) word = f[k*BIT_WIDTH +: BIT_WIDTH];
    end
    for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
      if (p == POS_W'(i)) b = word[BIT_WIDTH-1-i];
    end
    return b;
  endfunction

  // Bit position following the current one, wrapping at the frame end.
  always_comb begin
    slot_n     = slot_q;
    pos_n      = pos_q + POS_W'(1);
    last_bit_c = (slot_q == SLOT_W'(SLOTS - 1)) && (pos_q == POS_W'(SLOT_BITS - 1));
    if (pos_q == POS_W'(SLOT_BITS - 1)) begin
      pos_n  = '0;
      slot_n = (slot_q == SLOT_W'(SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
    sync_next_c = (slot_n == SLOT_W'(SLOTS - 1)) && (pos_n == POS_W'(SLOT_BITS - 1));
  end

  assign accept_c = valid_in && ready_q;

  // Next-state and output decode; serial outputs only move on the sck falling edge.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    pos_d    = pos_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    ready_d  = ready_q;
    ws_d     = ws_q;
    sd_d     = sd_q;
    ur_d     = 1'b0;

    if (accept_c) begin
      shadow_d = samples_in;
      ready_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        ws_d = 1'b0;
        sd_d = 1'b0;
        if (enable_in) begin
          state_d = RUN;
          slot_d  = SLOT_W'(SLOTS - 1);
          pos_d   = POS_W'(SLOT_BITS - 1);
          ws_d    = 1'b1;
        end
      end
      RUN: begin
        if (sck_fall_c) begin
          slot_d = slot_n;
          pos_d  = pos_n;
          ws_d   = 1'b0;
          if (sync_next_c) begin
            if (enable_in) begin
              ws_d = 1'b1;
              sd_d = bit_at(frame_q, slot_n, pos_n);
            end else begin
              state_d = IDLE;
              sd_d    = 1'b0;
            end
          end else if (last_bit_c) begin
            // Frame load: a word accepted on this same edge only serves the next frame.
            if (!ready_q) begin
              frame_d = shadow_q;
              ready_d = 1'b1;
            end else begin
              ur_d = 1'b1;
`ifdef TDM_TX_REPEAT_EN
              frame_d = frame_q;
`else
              frame_d = '0;
`endif
            end
            sd_d = bit_at(frame_d, '0, '0);
          end else begin
            sd_d = bit_at(frame_q, slot_n, pos_n);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      pos_q    <= '0;
      frame_q  <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      ws_q     <= 1'b0;
      sd_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      pos_q    <= pos_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      ws_q     <= ws_d;
      sd_q     <= sd_d;
      ur_q     <= ur_d;
    end
  end

  assign ready_out    = ready_q;
  assign ws_out       = ws_q;
  assign sd_out       = sd_q;
  assign underrun_out = ur_q;

endmodule
